// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one downstream memory port between instruction fetch and data access.
// Grants are registered (one cycle of latency), alternate on contention, and chain back-to-back without an idle bubble.
package mem_port_pkg;
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module mem_port_arbiter
  import mem_port_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output dbus_req_t  mreq,
  input  dbus_resp_t mresp,
  output logic [1:0] owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  state_t    state_q, state_d;
  logic      last_owner_q, last_owner_d;  // 0 = fetch, 1 = data
  dbus_req_t req_q, req_d;
  dbus_req_t fetch_req, data_req;

  // Both requests are normalised to the downstream format so the register holds exactly what mreq drives.
  always_comb begin
    fetch_req       = '0;
    fetch_req.valid = 1'b1;
    fetch_req.addr  = ireq.addr;
    fetch_req.size  = MSIZE4;
    data_req        = dreq;
    data_req.valid  = 1'b1;
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
    state_d      = state_q;
    last_owner_d = last_owner_q;
    req_d        = req_q;
    unique case (state_q)
      IDLE: begin
        if (dreq.valid && (!ireq.valid || !last_owner_q)) begin
          state_d      = BUSY_D;
          last_owner_d = 1'b1;
          req_d        = data_req;
        end else if (ireq.valid) begin
          state_d      = BUSY_I;
          last_owner_d = 1'b0;
          req_d        = fetch_req;
        end
      end
      BUSY_I: begin
        if (mresp.data_ok) begin
          if (dreq.valid) begin
            state_d      = BUSY_D;
            last_owner_d = 1'b1;
            req_d        = data_req;
          end else begin
            state_d = IDLE;
          end
        end
      end
      BUSY_D: begin
        if (mresp.data_ok) begin
          if (ireq.valid) begin
            state_d      = BUSY_I;
            last_owner_d = 1'b0;
            req_d        = fetch_req;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b0;
      req_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      req_q        <= req_d;
    end
  end

  // Only the owner sees the downstream handshake; a fetch picks its 32-bit lane by addr[2].
  always_comb begin
    mreq  = '0;
    iresp = '0;
    dresp = '0;
    unique case (state_q)
      BUSY_I: begin
        mreq          = req_q;
        iresp.addr_ok = mresp.addr_ok;
        iresp.data_ok = mresp.data_ok;
        iresp.data    = req_q.addr[2] ? mresp.data[63:32] : mresp.data[31:0];
      end
      BUSY_D: begin
        mreq  = req_q;
        dresp = mresp;
      end
      default: ;
    endcase
  end

  assign owner = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single fetch, store pass-through,
// contention/alternation, non-owner isolation, spurious data_ok and mid-transaction reset.
module tb_mem_port_arbiter;
  import mem_port_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  mreq;
  dbus_resp_t mresp;
  logic [1:0] owner;

  int total = 0;
  int bad   = 0;

  dbus_req_t exp_req;
  dbus_req_t store_req;

  mem_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .mreq  (mreq),
    .mresp (mresp),
    .owner (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then let combinational outputs settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;
    mresp = '0;
    tick();
    tick();
    check("reset_owner", owner, 2'b00);
    check("reset_mreq", mreq, '0);
    reset = 1'b0;
    tick();
    check("post_reset_owner", owner, 2'b00);
    check("post_reset_iresp", iresp, '0);
    check("post_reset_dresp", dresp, '0);

    // Spurious data_ok in IDLE is ignored.
    mresp.addr_ok = 1'b1;
    mresp.data_ok = 1'b1;
    mresp.data    = 64'hAAAA_BBBB_CCCC_DDDD;
    settle();
    check("idle_spur_iresp", iresp, '0);
    check("idle_spur_dresp", dresp, '0);
    tick();
    check("idle_spur_owner", owner, 2'b00);
    check("idle_spur_mreq", mreq, '0);
    mresp = '0;

    // Single fetch with two wait cycles.
    ireq.valid = 1'b1;
    ireq.addr  = 32'h8000_0004;
    settle();
    check("fetch_no_comb_fwd", mreq, '0);
    tick();
    exp_req        = '0;
    exp_req.valid  = 1'b1;
    exp_req.addr   = 32'h8000_0004;
    exp_req.size   = MSIZE4;
    check("fetch_owner", owner, 2'b01);
    check("fetch_mreq", mreq, exp_req);
    tick();
    check("fetch_wait1_mreq", mreq, exp_req);
    tick();
    check("fetch_wait2_mreq", mreq, exp_req);
    check("fetch_wait2_iresp", iresp, '0);
    mresp.data_ok = 1'b1;
    mresp.data    = 64'h1111_2222_3333_4444;
    settle();
    check("fetch_data_ok", iresp.data_ok, 1'b1);
    check("fetch_data_hi", iresp.data, 32'h1111_2222);
    check("fetch_done_mreq", mreq, exp_req);
    check("fetch_dresp_zero", dresp, '0);
    tick();
    ireq  = '0;
    mresp = '0;
    settle();
    check("fetch_no_regrant", owner, 2'b00);
    check("fetch_idle_mreq", mreq, '0);

    // Store pass-through.
    store_req        = '0;
    store_req.valid  = 1'b1;
    store_req.addr   = 32'h0000_0010;
    store_req.size   = MSIZE8;
    store_req.strobe = 8'hFF;
    store_req.data   = 64'hDEAD_BEEF_0000_0001;
    dreq = store_req;
    tick();
    check("store_owner", owner, 2'b10);
    check("store_mreq", mreq, store_req);
    mresp.addr_ok = 1'b1;
    settle();
    check("store_addr_ok", dresp.addr_ok, 1'b1);
    check("store_iresp_zero", iresp, '0);
    tick();
    mresp.addr_ok = 1'b0;
    check("store_hold_mreq", mreq, store_req);
    mresp.data_ok = 1'b1;
    mresp.data    = 64'h0123_4567_89AB_CDEF;
    settle();
    check("store_data_ok", dresp.data_ok, 1'b1);
    check("store_data", dresp.data, 64'h0123_4567_89AB_CDEF);
    check("store_iresp_done", iresp, '0);
    tick();
    dreq  = '0;
    mresp = '0;
    check("store_idle", owner, 2'b00);

    // Contention right after reset: data first, then fetch directly, then data again.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ireq.valid = 1'b1;
    ireq.addr  = 32'h0000_0100;
    dreq       = store_req;
    tick();
    check("both_first_is_d", owner, 2'b10);
    check("both_d_mreq", mreq, store_req);
    mresp.data_ok = 1'b1;
    mresp.data    = 64'h5555_6666_7777_8888;
    tick();
    dreq  = '0;
    mresp = '0;
    exp_req       = '0;
    exp_req.valid = 1'b1;
    exp_req.addr  = 32'h0000_0100;
    exp_req.size  = MSIZE4;
    check("chain_to_i_owner", owner, 2'b01);
    check("chain_to_i_mreq", mreq, exp_req);

    // Non-owner isolation while fetch owns the port.
    dreq           = store_req;
    dreq.addr      = 32'h0000_0200;
    mresp.addr_ok  = 1'b1;
    settle();
    check("iso_dresp_addr", dresp, '0);
    check("iso_iresp_addr_ok", iresp.addr_ok, 1'b1);
    tick();
    mresp.addr_ok = 1'b0;
    mresp.data_ok = 1'b1;
    mresp.data    = 64'h9999_AAAA_BBBB_CCCC;
    settle();
    check("iso_dresp_data", dresp, '0);
    check("iso_iresp_data_lo", iresp.data, 32'hBBBB_CCCC);
    check("iso_iresp_data_ok", iresp.data_ok, 1'b1);
    tick();
    ireq  = '0;
    mresp = '0;
    exp_req      = store_req;
    exp_req.addr = 32'h0000_0200;
    check("alt_d_granted", owner, 2'b10);
    check("alt_d_mreq", mreq, exp_req);

    // Reset mid-transaction after three wait cycles.
    tick();
    tick();
    tick();
    check("mid_wait_owner", owner, 2'b10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dreq  = '0;
    check("mid_reset_owner", owner, 2'b00);
    check("mid_reset_mreq_valid", mreq.valid, 1'b0);
    mresp.data_ok = 1'b1;
    mresp.data    = 64'hFFFF_0000_FFFF_0000;
    settle();
    check("late_data_ok_dresp", dresp.data_ok, 1'b0);
    check("late_data_ok_iresp", iresp, '0);
    tick();
    mresp = '0;
    check("late_data_ok_owner", owner, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
